// File: rtl/blake512_pkg.sv
// rtl/blake512_pkg.sv - shared BLAKE-512 header padding layout constants, states and pad check
package blake512_pkg;

  localparam int HDR_BITS  = 640;
  localparam int BLK_BITS  = 1024;
  localparam int HDR_WORDS = 20;

  localparam logic [7:0]  PAD_START = 8'h80;
  localparam logic [7:0]  PAD_END   = 8'h01;
  localparam logic [63:0] T0_HDR    = 64'h280;

  localparam int PAD_START_LSB = 376;
  localparam int PAD_END_LSB   = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_REJECT
  } state_e;

  // True when the block carries exactly the padding and counter an 80-byte header produces.
  function automatic logic pad_ok(input logic [BLK_BITS-1:0] blk);
    return (blk[PAD_START_LSB +: 8] == PAD_START) &&
           (blk[PAD_START_LSB-1:PAD_END_LSB+8] == '0) &&
           (blk[PAD_END_LSB +: 8] == PAD_END) &&
           (blk[127:64] == '0) &&
           (blk[63:0] == T0_HDR);
  endfunction

endpackage

// File: rtl/bswap32.sv
// rtl/bswap32.sv - 32-bit byte reverse
module bswap32 (
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  assign data_o = {data_i[7:0], data_i[15:8], data_i[23:16], data_i[31:24]};

endmodule

// File: rtl/unpadding.sv
// rtl/unpadding.sv - checks a padded BLAKE-512 header block and streams the 20 header words back out
module unpadding
  import blake512_pkg::*;
#(
  parameter int CHECK_PAD = 1,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLK_BITS-1:0]  in_block,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [4:0]           out_idx,
  output logic                 out_last,
  output logic                 pad_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int KEEP_BITS = HDR_BITS - 32;

  state_e                 state_q;
  logic [KEEP_BITS-1:0]   blk_q;
  logic [4:0]             idx_q;
  logic                   out_valid_q;
  logic [31:0]            out_data_q;
  logic                   out_last_q;
  logic                   pad_err_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  logic [31:0]            raw_w;
  logic [31:0]            swap_w;
  logic                   accept_ok;

  // Word 0 is loaded straight from the input at accept; blk_q holds words 1..19 as a shift register.
  assign raw_w     = (state_q == ST_IDLE) ? in_block[BLK_BITS-1 -: 32] : blk_q[KEEP_BITS-1 -: 32];
  assign accept_ok = pad_ok(in_block) || (CHECK_PAD == 0);
  assign in_ready  = (state_q == ST_IDLE) && !rst;

  bswap32 u_bswap (
    .data_i (raw_w),
    .data_o (swap_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      pad_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pad_err_q <= 1'b0;
          if (in_valid) begin
            blk_q <= in_block[BLK_BITS-33 -: KEEP_BITS];
            if (accept_ok) begin
              state_q     <= ST_EMIT;
              idx_q       <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= swap_w;
              out_last_q  <= 1'b0;
            end else begin
              state_q   <= ST_REJECT;
              pad_err_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            end
          end
        end
        ST_REJECT: begin
          pad_err_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (idx_q == 5'(HDR_WORDS - 1)) begin
              state_q     <= ST_IDLE;
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              idx_q      <= idx_q + 5'd1;
              out_data_q <= swap_w;
              out_last_q <= (idx_q == 5'(HDR_WORDS - 2));
              blk_q      <= {blk_q[KEEP_BITS-33:0], 32'h0};
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign pad_err   = pad_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_unpadding.sv
// tb/tb_unpadding.sv - randomized self-checking bench for unpadding against a byte-level header model
module tb_unpadding;

  logic          clk = 1'b0;
  logic          rst;
  logic          iv_a, iv_b, iv_c;
  logic [1023:0] in_block;
  logic          out_ready;

  logic          rdy_a, ov_a, ol_a, pe_a;
  logic [31:0]   od_a;
  logic [4:0]    oi_a;
  logic [15:0]   ec_a;
  logic          rdy_b, ov_b, ol_b, pe_b;
  logic [31:0]   od_b;
  logic [4:0]    oi_b;
  logic [15:0]   ec_b;
  logic          rdy_c, ov_c, ol_c, pe_c;
  logic [31:0]   od_c;
  logic [4:0]    oi_c;
  logic [1:0]    ec_c;

  always #5 clk = ~clk;

  unpadding dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(rdy_a), .in_block(in_block),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_idx(oi_a),
    .out_last(ol_a), .pad_err(pe_a), .err_cnt(ec_a)
  );

  unpadding #(.CHECK_PAD(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(rdy_b), .in_block(in_block),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_idx(oi_b),
    .out_last(ol_b), .pad_err(pe_b), .err_cnt(ec_b)
  );

  unpadding #(.ERR_CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(rdy_c), .in_block(in_block),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .out_idx(oi_c),
    .out_last(ol_c), .pad_err(pe_c), .err_cnt(ec_c)
  );

  int          sel;
  logic        v_rdy, v_valid, v_last, v_pe;
  logic [31:0] v_data;
  logic [4:0]  v_idx;
  logic [15:0] v_cnt;

  always_comb begin
    v_rdy = rdy_a; v_valid = ov_a; v_data = od_a; v_idx = oi_a;
    v_last = ol_a; v_pe = pe_a; v_cnt = ec_a;
    if (sel == 1) begin
      v_rdy = rdy_b; v_valid = ov_b; v_data = od_b; v_idx = oi_b;
      v_last = ol_b; v_pe = pe_b; v_cnt = ec_b;
    end else if (sel == 2) begin
      v_rdy = rdy_c; v_valid = ov_c; v_data = od_c; v_idx = oi_c;
      v_last = ol_c; v_pe = pe_c; v_cnt = {14'd0, ec_c};
    end
  end

  int pulses [3];
  always @(negedge clk) begin
    if (pe_a === 1'b1) pulses[0]++;
    if (pe_b === 1'b1) pulses[1]++;
    if (pe_c === 1'b1) pulses[2]++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0]    hdr   [80];
  logic [31:0]   exp_w [20];
  logic [1023:0] blk;

  task automatic seq_hdr();
    for (int i = 0; i < 80; i++) hdr[i] = 8'(i);
  endtask

  task automatic rand_hdr();
    for (int i = 0; i < 80; i++) hdr[i] = 8'($urandom);
  endtask

  // Padder model: header bytes big-endian, each 32-bit word byte-swapped, then pad bytes and T0=640.
  task automatic make_block();
    blk = '0;
    for (int i = 0; i < 20; i++) begin
      blk[1023-32*i -: 32] = {hdr[4*i+3], hdr[4*i+2], hdr[4*i+1], hdr[4*i]};
      exp_w[i]             = {hdr[4*i], hdr[4*i+1], hdr[4*i+2], hdr[4*i+3]};
    end
    blk[383:376] = 8'h80;
    blk[135:128] = 8'h01;
    blk[63:0]    = 64'h280;
  endtask

  task automatic send(input int s, input logic [1023:0] b);
    sel = s;
    #1;
    check("in_ready_before_accept", {63'd0, v_rdy}, 64'd1);
    in_block = b;
    iv_a = (s == 0); iv_b = (s == 1); iv_c = (s == 2);
    @(negedge clk);
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    in_block = {32{$urandom()}};
  endtask

  task automatic collect(input int stall_pct, input bit timing, input int abort_at);
    int k = 0;
    int c = 1;
    bit held = 0;
    bit rdy;
    logic [31:0] hd;
    logic [4:0] hi;
    while (k < 20 && c < 400) begin
      if (k == abort_at) return;
      if (held) begin
        check("stall_data_stable", {32'd0, v_data}, {32'd0, hd});
        check("stall_idx_stable", {59'd0, v_idx}, {59'd0, hi});
      end
      check("out_valid_streaming", {63'd0, v_valid}, 64'd1);
      check("in_ready_streaming", {63'd0, v_rdy}, 64'd0);
      rdy = ($urandom_range(99) >= stall_pct);
      out_ready = rdy;
      if (rdy) begin
        check("out_data", {32'd0, v_data}, {32'd0, exp_w[k]});
        check("out_idx", {59'd0, v_idx}, 64'(k));
        check("out_last", {63'd0, v_last}, {63'd0, (k == 19)});
        if (timing) check("word_latency", 64'(c), 64'(k + 1));
        k++;
        held = 0;
      end else begin
        held = 1;
        hd = v_data;
        hi = v_idx;
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b1;
    if (k < 20) check("stream_timeout", 64'(k), 64'd20);
    check("out_valid_after_stream", {63'd0, v_valid}, 64'd0);
    check("in_ready_after_stream", {63'd0, v_rdy}, 64'd1);
    if (timing) check("in_ready_cycle", 64'(c), 64'd21);
  endtask

  task automatic bad(input int s, input logic [1023:0] b, input int exp_cnt);
    send(s, b);
    check("pad_err_pulse", {63'd0, v_pe}, 64'd1);
    check("err_cnt", {48'd0, v_cnt}, 64'(exp_cnt));
    check("reject_no_valid", {63'd0, v_valid}, 64'd0);
    check("reject_in_ready", {63'd0, v_rdy}, 64'd0);
    @(negedge clk);
    check("reject_ready_back", {63'd0, v_rdy}, 64'd1);
    check("reject_pulse_end", {63'd0, v_pe}, 64'd0);
    check("reject_still_no_valid", {63'd0, v_valid}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [1023:0] b;
    rst = 1'b1; iv_a = 0; iv_b = 0; iv_c = 0; in_block = '0; out_ready = 1'b1; sel = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, rdy_a}, 64'd0);
    check("rst_out_valid", {63'd0, ov_a}, 64'd0);
    check("rst_out_data", {32'd0, od_a}, 64'd0);
    check("rst_out_idx", {59'd0, oi_a}, 64'd0);
    check("rst_out_last", {63'd0, ol_a}, 64'd0);
    check("rst_pad_err", {63'd0, pe_a}, 64'd0);
    check("rst_err_cnt", {48'd0, ec_a}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    seq_hdr(); make_block();
    send(0, blk); collect(0, 1, 99);
    check("seq_first_word", {32'd0, exp_w[0]}, 64'h00010203);
    send(0, blk); collect(30, 0, 99);
    for (int n = 0; n < 3; n++) begin
      rand_hdr(); make_block();
      send(0, blk); collect(30, 0, 99);
    end
    check("good_blocks_no_pad_err", 64'(pulses[0]), 64'd0);

    seq_hdr(); make_block();
    b = blk; b[63:0] = 64'h200;              bad(0, b, 1);
    b = blk; b[135:128] = 8'h00;             bad(0, b, 2);
    b = blk; b[383:376] = 8'h81;             bad(0, b, 3);
    b = blk; b[64 + $urandom_range(63)] = 1'b1;   bad(0, b, 4);
    b = blk; b[136 + $urandom_range(239)] = 1'b1; bad(0, b, 5);
    check("bad_block_pulses", 64'(pulses[0]), 64'd5);

    b = blk; b[383:376] = 8'h00;
    send(1, b); collect(0, 1, 99);
    check("nocheck_no_pad_err", 64'(pulses[1]), 64'd0);

    for (int i = 1; i <= 4; i++) begin
      b = blk; b[63:0] = 64'h200 + 64'(i);
      bad(2, b, (i > 3) ? 3 : i);
    end
    check("sat_pulses", 64'(pulses[2]), 64'd4);

    rand_hdr(); make_block();
    send(0, blk); collect(0, 0, 7);
    check("pre_rst_word7_idx", {59'd0, oi_a}, 64'd7);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, ov_a}, 64'd0);
    check("midrst_out_data", {32'd0, od_a}, 64'd0);
    check("midrst_out_idx", {59'd0, oi_a}, 64'd0);
    check("midrst_out_last", {63'd0, ol_a}, 64'd0);
    check("midrst_pad_err", {63'd0, pe_a}, 64'd0);
    check("midrst_err_cnt", {48'd0, ec_a}, 64'd0);
    check("midrst_in_ready", {63'd0, rdy_a}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_no_valid", {63'd0, ov_a}, 64'd0);
    rand_hdr(); make_block();
    send(0, blk); collect(20, 0, 99);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
